adder_share_arbiter: RTL and testbench

- Shares one combinational 8-bit ripple-carry adder among NREQ requesters.
- Each requester has a valid/ready request channel carrying A, B and carry-in, and a valid/ready response channel returning sum and carry-out.
- A round-robin arbiter grants one request at a time and registers its operands onto the adder.
- The block waits SETTLE_CYC cycles for the ripple chain to settle, captures the result, and holds the response until the granted requester accepts it.

---
 rtl/adder_share_arbiter.sv | 139 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external 8-bit ripple-carry adder
// among NREQ valid/ready requesters, holding each result until it is accepted.
module adder_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 2,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [7:0]        resp_sum,
  output logic              resp_cout,
  output logic [7:0]        adder_a,
  output logic [7:0]        adder_b,
  output logic              adder_cin,
  input  logic [7:0]        adder_sum,
  input  logic              adder_cout,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

  localparam int            CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           cin_q, cin_d, cout_q, cout_d;

  logic           win_any;
  logic [IDW-1:0] win_id;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the lowest priority down so the last hit is the requester closest to rr_ptr.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr_q, k)]) begin
        win_any = 1'b1;
        win_id  = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        // Reset takes precedence: no requester may see a handshake that is then dropped.
        if (win_any && !rst) begin
          req_ready[win_id] = 1'b1;
          a_d      = req_a[8*int'(win_id) +: 8];
          b_d      = req_b[8*int'(win_id) +: 8];
          cin_d    = req_cin[win_id];
          grant_d  = win_id;
          rr_ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          sum_d   = adder_sum;
          cout_d  = adder_cout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign adder_a   = a_q;
  assign adder_b   = b_q;
  assign adder_cin = cin_q;
  assign resp_sum  = sum_q;
  assign resp_cout = cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: main instance with SETTLE_CYC=2 and
// two side instances (SETTLE_CYC=1 and 4) for the latency sweep.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req_valid, req_ready, req_cin, resp_valid, resp_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  resp_sum, adder_a, adder_b, adder_sum;
  logic        resp_cout, adder_cin, adder_cout, busy;
  logic [1:0]  grant_id;

  logic [3:0]  s_valid, s_cin, s_resp_ready;
  logic [31:0] s_a, s_b;

  logic [3:0]  s1_req_ready, s1_resp_valid;
  logic [7:0]  s1_resp_sum, s1_adder_a, s1_adder_b, s1_adder_sum;
  logic        s1_resp_cout, s1_adder_cin, s1_adder_cout, s1_busy;
  logic [1:0]  s1_grant_id;

  logic [3:0]  s4_req_ready, s4_resp_valid;
  logic [7:0]  s4_resp_sum, s4_adder_a, s4_adder_b, s4_adder_sum;
  logic        s4_resp_cout, s4_adder_cin, s4_adder_cout, s4_busy;
  logic [1:0]  s4_grant_id;

  int n_cmp = 0;
  int n_err = 0;

  // External ripple adder models
  assign {adder_cout, adder_sum}       = {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};
  assign {s1_adder_cout, s1_adder_sum} = {1'b0, s1_adder_a} + {1'b0, s1_adder_b} + {8'b0, s1_adder_cin};
  assign {s4_adder_cout, s4_adder_sum} = {1'b0, s4_adder_a} + {1'b0, s4_adder_b} + {8'b0, s4_adder_cin};

  adder_share_arbiter #(.NREQ(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout), .busy(busy), .grant_id(grant_id)
  );

  adder_share_arbiter #(.NREQ(4), .SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req_valid(s_valid), .req_ready(s1_req_ready), .req_a(s_a), .req_b(s_b), .req_cin(s_cin),
    .resp_valid(s1_resp_valid), .resp_ready(s_resp_ready), .resp_sum(s1_resp_sum), .resp_cout(s1_resp_cout),
    .adder_a(s1_adder_a), .adder_b(s1_adder_b), .adder_cin(s1_adder_cin),
    .adder_sum(s1_adder_sum), .adder_cout(s1_adder_cout), .busy(s1_busy), .grant_id(s1_grant_id)
  );

  adder_share_arbiter #(.NREQ(4), .SETTLE_CYC(4)) dut_s4 (
    .clk(clk), .rst(rst),
    .req_valid(s_valid), .req_ready(s4_req_ready), .req_a(s_a), .req_b(s_b), .req_cin(s_cin),
    .resp_valid(s4_resp_valid), .resp_ready(s_resp_ready), .resp_sum(s4_resp_sum), .resp_cout(s4_resp_cout),
    .adder_a(s4_adder_a), .adder_b(s4_adder_b), .adder_cin(s4_adder_cin),
    .adder_sum(s4_adder_sum), .adder_cout(s4_adder_cout), .busy(s4_busy), .grant_id(s4_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_cin[i]      = c;
  endtask

  // Single-requester transaction on the SETTLE_CYC=2 instance, starting in IDLE.
  task automatic txn(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] exp_sum, input logic exp_cout);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    set_req(id, a, b, c);
    req_valid = oh;
    #1;
    check({tag, "_ready"}, req_ready, oh);
    step();                                   // cycle 1: ISSUE
    req_valid = 4'b0;
    #1;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_ready_busy"}, req_ready, 4'b0);
    check({tag, "_adder_a"}, adder_a, a);
    check({tag, "_adder_b"}, adder_b, b);
    check({tag, "_adder_cin"}, adder_cin, c);
    check({tag, "_grant"}, grant_id, id);
    check({tag, "_rv_c1"}, resp_valid, 4'b0);
    step();                                   // cycle 2: ISSUE
    check({tag, "_rv_c2"}, resp_valid, 4'b0);
    check({tag, "_adder_a_c2"}, adder_a, a);
    step();                                   // cycle 3: RESP
    check({tag, "_rv_c3"}, resp_valid, oh);
    check({tag, "_sum"}, resp_sum, exp_sum);
    check({tag, "_cout"}, resp_cout, exp_cout);
    resp_ready = oh;
    step();
    check({tag, "_rv_done"}, resp_valid, 4'b0);
    check({tag, "_idle"}, busy, 1'b0);
    resp_ready = 4'b0;
  endtask

  logic [7:0] ta [4] = '{8'h11, 8'h80, 8'hF0, 8'h7F};
  logic [7:0] tb [4] = '{8'h22, 8'h80, 8'h0F, 8'h01};
  logic       tc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] es [4] = '{8'h34, 8'h00, 8'hFF, 8'h81};
  logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; resp_ready = '0;
    s_valid = '0; s_a = '0; s_b = '0; s_cin = '0; s_resp_ready = '0;
    step();
    step();
    check("rst_ready", req_ready, 4'b0);
    check("rst_rv", resp_valid, 4'b0);
    check("rst_sum", resp_sum, 8'h00);
    check("rst_cout", resp_cout, 1'b0);
    check("rst_adder", {adder_cin, adder_a, adder_b}, 17'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    rst = 1'b0;
    step();

    // Basic transactions
    txn("t1", 0, 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0);
    txn("t2", 2, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
    step();
    check("t2_sum_hold", resp_sum, 8'h01);
    check("t2_grant_hold", grant_id, 2'd2);

    // Reset from IDLE so the round-robin pointer starts at 0 again
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_sum", resp_sum, 8'h00);
    check("rst2_grant", grant_id, 2'd0);

    // All requesters valid: grants rotate 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i], tc[i]);
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      check($sformatf("rr%0d_ready", n), req_ready, 4'b0001 << (n % 4));
      step();
      check($sformatf("rr%0d_ready_busy", n), req_ready, 4'b0);
      step();
      step();
      check($sformatf("rr%0d_rv", n), resp_valid, 4'b0001 << (n % 4));
      check($sformatf("rr%0d_sum", n), resp_sum, es[n % 4]);
      check($sformatf("rr%0d_cout", n), resp_cout, ec[n % 4]);
      check($sformatf("rr%0d_grant", n), grant_id, n % 4);
      step();
    end
    req_valid  = 4'b0;
    resp_ready = 4'b0;
    step();

    // Requester 1 stalls its response for 5 cycles
    set_req(1, 8'h55, 8'h2A, 1'b1);
    req_valid = 4'b0010;
    #1;
    check("bp_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'b1000;
    step();
    step();
    resp_ready = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_rv", k), resp_valid, 4'b0010);
      check($sformatf("bp%0d_sum", k), resp_sum, 8'h80);
      check($sformatf("bp%0d_cout", k), resp_cout, 1'b0);
      check($sformatf("bp%0d_ready", k), req_ready, 4'b0);
      step();
    end
    resp_ready = 4'b0010;
    #1;
    check("bp_rv_last", resp_valid, 4'b0010);
    step();
    check("bp_rv_drop", resp_valid, 4'b0);
    check("bp_idle", busy, 1'b0);
    check("bp_next_ready", req_ready, 4'b1000);
    check("bp_grant_hold", grant_id, 2'd1);
    req_valid  = 4'b0;
    resp_ready = 4'b0;
    step();
    check("bp_no_grant", busy, 1'b0);

    // Reset during ISSUE discards the transaction
    set_req(3, 8'h01, 8'h02, 1'b0);
    req_valid = 4'b1000;
    #1;
    check("ri_ready", req_ready, 4'b1000);
    step();
    rst = 1'b1;
    step();
    check("ri_ready0", req_ready, 4'b0);
    check("ri_rv", resp_valid, 4'b0);
    check("ri_sum", resp_sum, 8'h00);
    check("ri_cout", resp_cout, 1'b0);
    check("ri_adder", {adder_cin, adder_a, adder_b}, 17'h0);
    check("ri_busy", busy, 1'b0);
    check("ri_grant", grant_id, 2'd0);
    step();
    check("ri_hold_busy", busy, 1'b0);
    rst = 1'b0;
    req_valid = 4'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ri_no_resp%0d", k), resp_valid, 4'b0);
    end
    txn("t5", 3, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Settle-time sweep on the SETTLE_CYC=1 and 4 instances
    s_a[7:0] = 8'hC8;
    s_b[7:0] = 8'h64;
    s_cin[0] = 1'b1;
    s_valid  = 4'b0001;
    #1;
    check("sw_s1_ready", s1_req_ready, 4'b0001);
    check("sw_s4_ready", s4_req_ready, 4'b0001);
    step();
    s_valid = 4'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("sw_s1_rv_c%0d", c), s1_resp_valid, (c >= 2) ? 4'b0001 : 4'b0000);
      check($sformatf("sw_s4_rv_c%0d", c), s4_resp_valid, (c >= 5) ? 4'b0001 : 4'b0000);
      check($sformatf("sw_s1_in_c%0d", c), {s1_adder_cin, s1_adder_a, s1_adder_b}, 17'h1C864);
      check($sformatf("sw_s4_in_c%0d", c), {s4_adder_cin, s4_adder_a, s4_adder_b}, 17'h1C864);
      if (c >= 2) check($sformatf("sw_s1_res_c%0d", c), {s1_resp_cout, s1_resp_sum}, 9'h12D);
      if (c >= 5) check($sformatf("sw_s4_res_c%0d", c), {s4_resp_cout, s4_resp_sum}, 9'h12D);
      step();
    end
    s_resp_ready = 4'b0001;
    step();
    check("sw_s1_idle", s1_busy, 1'b0);
    check("sw_s4_idle", s4_busy, 1'b0);
    s_resp_ready = 4'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
